// File: rtl/dehaze_pkg.sv
// -----------------------------------------------------------------------------
// dehaze_pkg
// Shared definitions for the dehaze pixel pipeline.
//   PIX_W      : default bits per colour channel
//   rgb_pix_t  : packed RGB pixel {r, g, b}, r in the most significant bits
//   cnt_w()    : width of a counter or address that indexes n positions
// -----------------------------------------------------------------------------
package dehaze_pkg;

  localparam int PIX_W = 8;

  typedef struct packed {
    logic [PIX_W-1:0] r;
    logic [PIX_W-1:0] g;
    logic [PIX_W-1:0] b;
  } rgb_pix_t;

  // Width needed to index 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rgb_window_3x3_gen_line_buffer.sv
// -----------------------------------------------------------------------------
// rgb_line_buffer
// One-line delay for packed RGB pixels. Location addr is read and then
// overwritten with din in the same enabled cycle, so dout shows the pixel
// that was written at this column one line earlier.
//   clk  : system clock
//   en   : write strobe (one accepted pixel)
//   addr : column index
//   din  : pixel to store
//   dout : pixel stored at addr (previous line)
// -----------------------------------------------------------------------------
module rgb_line_buffer
  import dehaze_pkg::*;
#(
  parameter int DEPTH = 640,
  parameter int W     = $bits(rgb_pix_t),
  localparam int AW   = cnt_w(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout
);

  logic [W-1:0] mem_q [DEPTH];

  // The window shifts on the same edge that accepts the pixel, so the old
  // line contents must be available combinationally at that edge. The
  // write lands at the edge, which gives read-before-write for free.
  assign dout = mem_q[addr];

  always_ff @(posedge clk) begin
    if (en) begin
      mem_q[addr] <= din;
    end
  end

endmodule

// File: rtl/rgb_window_3x3_gen.sv
// -----------------------------------------------------------------------------
// rgb_window_3x3_gen
// Turns a raster-scan RGB stream into 3x3 window taps (a..i per colour).
//   a b c : row y-2, cols x-2..x
//   d e f : row y-1 (e is the window centre)
//   g h i : row y   (i is the pixel just accepted)
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   in_valid, in_sof      : pixel strobe, start-of-frame (qualified by in_valid)
//   in_r, in_g, in_b      : incoming pixel
//   a_r..i_r/_g/_b        : window taps, registered on the accepting edge
//   out_valid             : taps hold a full interior window (x>=2, y>=2)
//   frame_done            : pulse after pixel (IMG_W-1, IMG_H-1) is accepted
// Optional build macro WIN_COORD_EN adds out_x/out_y, the window centre.
// -----------------------------------------------------------------------------
module rgb_window_3x3_gen
  import dehaze_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int PIX_W = dehaze_pkg::PIX_W,
  localparam int XW   = cnt_w(IMG_W),
  localparam int YW   = cnt_w(IMG_H)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [PIX_W-1:0] in_r,
  input  logic [PIX_W-1:0] in_g,
  input  logic [PIX_W-1:0] in_b,
  output logic [PIX_W-1:0] a_r, b_r, c_r, d_r, e_r, f_r, g_r, h_r, i_r,
  output logic [PIX_W-1:0] a_g, b_g, c_g, d_g, e_g, f_g, g_g, h_g, i_g,
  output logic [PIX_W-1:0] a_b, b_b, c_b, d_b, e_b, f_b, g_b, h_b, i_b,
`ifdef WIN_COORD_EN
  output logic [XW-1:0]    out_x,
  output logic [YW-1:0]    out_y,
`endif
  output logic             out_valid,
  output logic             frame_done
);

  typedef struct packed {
    logic [PIX_W-1:0] r;
    logic [PIX_W-1:0] g;
    logic [PIX_W-1:0] b;
  } pix_t;

  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          out_valid_q, out_valid_d;
  logic          frame_done_q, frame_done_d;
  pix_t          win_q [3][3];
  pix_t          win_d [3][3];

  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  pix_t          in_pix;
  pix_t          lb1_pix;
  pix_t          lb2_pix;
  logic [3*PIX_W-1:0] lb1_dout, lb2_dout;

  assign in_pix = '{r: in_r, g: in_g, b: in_b};

  // A start-of-frame pixel is (0,0) whatever the counters say.
  assign pix_x = in_sof ? '0 : x_q;
  assign pix_y = in_sof ? '0 : y_q;

  // ---------------------------------------------------------------------------
  // Line buffers: lb1 delays by one line, lb2 (fed from lb1) by two.
  // ---------------------------------------------------------------------------
  rgb_line_buffer #(
    .DEPTH (IMG_W),
    .W     (3*PIX_W)
  ) u_lb1 (
    .clk  (clk),
    .en   (in_valid),
    .addr (pix_x),
    .din  (in_pix),
    .dout (lb1_dout)
  );

  rgb_line_buffer #(
    .DEPTH (IMG_W),
    .W     (3*PIX_W)
  ) u_lb2 (
    .clk  (clk),
    .en   (in_valid),
    .addr (pix_x),
    .din  (lb1_dout),
    .dout (lb2_dout)
  );

  assign lb1_pix = pix_t'(lb1_dout);
  assign lb2_pix = pix_t'(lb2_dout);

  // ---------------------------------------------------------------------------
  // Raster counters and strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    x_d          = x_q;
    y_d          = y_q;
    out_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    if (in_valid) begin
      out_valid_d = (pix_x >= XW'(2)) && (pix_y >= YW'(2));
      if (pix_x == X_LAST) begin
        x_d = '0;
        if (pix_y == Y_LAST) begin
          y_d          = '0;
          frame_done_d = 1'b1;
        end else begin
          y_d = pix_y + YW'(1);
        end
      end else begin
        x_d = pix_x + XW'(1);
        y_d = pix_y;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // 3x3 window: rows shift left, new column {lb2, lb1, in} enters on the right.
  // ---------------------------------------------------------------------------
  always_comb begin
    win_d = win_q;
    if (in_valid) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = lb2_pix;
      win_d[1][2] = lb1_pix;
      win_d[2][2] = in_pix;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q          <= '0;
      y_q          <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      x_q          <= x_d;
      y_q          <= y_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
      win_q        <= win_d;
    end
  end

`ifdef WIN_COORD_EN
  // Window centre is one column left and one row up from the accepted pixel.
  logic [XW-1:0] out_x_q, out_x_d;
  logic [YW-1:0] out_y_q, out_y_d;

  always_comb begin
    out_x_d = out_x_q;
    out_y_d = out_y_q;
    if (in_valid) begin
      out_x_d = pix_x - XW'(1);
      out_y_d = pix_y - YW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_x_q <= '0;
      out_y_q <= '0;
    end else begin
      out_x_q <= out_x_d;
      out_y_q <= out_y_d;
    end
  end

  assign out_x = out_x_q;
  assign out_y = out_y_q;
`endif

  // ---------------------------------------------------------------------------
  // Output taps
  // ---------------------------------------------------------------------------
  assign a_r = win_q[0][0].r;  assign a_g = win_q[0][0].g;  assign a_b = win_q[0][0].b;
  assign b_r = win_q[0][1].r;  assign b_g = win_q[0][1].g;  assign b_b = win_q[0][1].b;
  assign c_r = win_q[0][2].r;  assign c_g = win_q[0][2].g;  assign c_b = win_q[0][2].b;
  assign d_r = win_q[1][0].r;  assign d_g = win_q[1][0].g;  assign d_b = win_q[1][0].b;
  assign e_r = win_q[1][1].r;  assign e_g = win_q[1][1].g;  assign e_b = win_q[1][1].b;
  assign f_r = win_q[1][2].r;  assign f_g = win_q[1][2].g;  assign f_b = win_q[1][2].b;
  assign g_r = win_q[2][0].r;  assign g_g = win_q[2][0].g;  assign g_b = win_q[2][0].b;
  assign h_r = win_q[2][1].r;  assign h_g = win_q[2][1].g;  assign h_b = win_q[2][1].b;
  assign i_r = win_q[2][2].r;  assign i_g = win_q[2][2].g;  assign i_b = win_q[2][2].b;

  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_rgb_window_3x3_gen.sv
module tb_rgb_window_3x3_gen;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int PW = 8;
  localparam int TW = 9 * 3 * PW;

  logic clk = 1'b0;
  logic rst_n, in_valid, in_sof;
  logic [PW-1:0] in_r, in_g, in_b;
  logic [PW-1:0] a_r, b_r, c_r, d_r, e_r, f_r, g_r, h_r, i_r;
  logic [PW-1:0] a_g, b_g, c_g, d_g, e_g, f_g, g_g, h_g, i_g;
  logic [PW-1:0] a_b, b_b, c_b, d_b, e_b, f_b, g_b, h_b, i_b;
  logic out_valid, frame_done;
`ifdef WIN_COORD_EN
  logic [2:0] out_x;
  logic [2:0] out_y;
`endif

  always #5 clk = ~clk;

  rgb_window_3x3_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof),
    .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .a_r(a_r), .b_r(b_r), .c_r(c_r), .d_r(d_r), .e_r(e_r), .f_r(f_r), .g_r(g_r), .h_r(h_r), .i_r(i_r),
    .a_g(a_g), .b_g(b_g), .c_g(c_g), .d_g(d_g), .e_g(e_g), .f_g(f_g), .g_g(g_g), .h_g(h_g), .i_g(i_g),
    .a_b(a_b), .b_b(b_b), .c_b(c_b), .d_b(d_b), .e_b(e_b), .f_b(f_b), .g_b(g_b), .h_b(h_b), .i_b(i_b),
`ifdef WIN_COORD_EN
    .out_x(out_x), .out_y(out_y),
`endif
    .out_valid(out_valid), .frame_done(frame_done)
  );

  logic [TW-1:0] obs_taps;
  assign obs_taps = {a_r, a_g, a_b, b_r, b_g, b_b, c_r, c_g, c_b,
                     d_r, d_g, d_b, e_r, e_g, e_b, f_r, f_g, f_b,
                     g_r, g_g, g_b, h_r, h_g, h_b, i_r, i_g, i_b};

  int checks   = 0;
  int failures = 0;

  logic [TW-1:0] sb_q[$];
  logic [5:0]    coord_q[$];
  int mx, my;
  int strobes;
  int acc_since;
  int first_at;
  bit hold_ok;
  logic [TW-1:0] hold_taps;
  int trans = 0;

  function automatic logic [PW-1:0] pv(input int x, input int y);
    return PW'(16 * y + x);
  endfunction

  function automatic logic [TW-1:0] exp_win(input int x, input int y);
    logic [TW-1:0] w;
    logic [PW-1:0] r;
    w = '0;
    for (int k = 0; k < 9; k++) begin
      r = pv(x - 2 + k % 3, y - 2 + k / 3);
      w = {w[TW-3*PW-1:0], r, r + 8'd1, r + 8'd2};
    end
    return w;
  endfunction

  task automatic chk(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One accepted pixel at the bench's model coordinate.
  task automatic drive_pix(input bit sof);
    bit exp_v, exp_fd;
    int cx, cy;
    logic [TW-1:0] e;
    logic [5:0] ec;
    if (sof) begin mx = 0; my = 0; end
    cx = mx; cy = my;
    in_valid = 1'b1; in_sof = sof;
    in_r = pv(cx, cy); in_g = pv(cx, cy) + 8'd1; in_b = pv(cx, cy) + 8'd2;
    exp_v  = (cx >= 2) && (cy >= 2);
    exp_fd = (cx == W - 1) && (cy == H - 1);
    if (exp_v) begin
      sb_q.push_back(exp_win(cx, cy));
      coord_q.push_back({3'(cx - 1), 3'(cy - 1)});
    end
    if (cx == W - 1) begin
      mx = 0; my = (cy == H - 1) ? 0 : cy + 1;
    end else begin
      mx = cx + 1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_sof = 1'b0;
    acc_since++;
    trans++;
    $display("tb: txn %0d pix (%0d,%0d) sof=%0b out_valid=%0b frame_done=%0b", trans, cx, cy, sof, out_valid, frame_done);
    chk("out_valid", TW'(out_valid), TW'(exp_v));
    chk("frame_done", TW'(frame_done), TW'(exp_fd));
    hold_ok = 1'b0;
    if (out_valid === 1'b1) begin
      strobes++;
      if (first_at < 0) first_at = acc_since;
      checks++;
      assert (sb_q.size() > 0) else begin
        failures++;
        $error("FAIL sb_underflow observed=%0d expected=%0d", 0, 1);
      end
      if (sb_q.size() > 0) begin
        e  = sb_q.pop_front();
        ec = coord_q.pop_front();
        chk("taps", obs_taps, e);
        hold_ok = 1'b1; hold_taps = e;
`ifdef WIN_COORD_EN
        chk("coord", TW'({out_x, out_y}), TW'(ec));
`else
        if (ec == 6'h3f) hold_ok = 1'b1;
`endif
        if (cx == 2 && cy == 2) begin
          chk("first_a_r", TW'(a_r), TW'(8'h00));
          chk("first_e_r", TW'(e_r), TW'(8'h11));
          chk("first_i_r", TW'(i_r), TW'(8'h22));
          chk("first_e_g", TW'(e_g), TW'(8'h12));
          chk("first_e_b", TW'(e_b), TW'(8'h13));
        end
        if (cx == 2 && cy == 3) begin
          chk("wrap_a_r", TW'(a_r), TW'(8'h10));
          chk("wrap_c_r", TW'(c_r), TW'(8'h12));
          chk("wrap_g_r", TW'(g_r), TW'(8'h30));
        end
      end
    end
  endtask

  // Idle cycle; a stray sof without valid must be ignored.
  task automatic idle();
    in_valid = 1'b0; in_sof = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    in_sof = 1'b0;
    chk("gap_out_valid", TW'(out_valid), TW'(0));
    chk("gap_frame_done", TW'(frame_done), TW'(0));
    if (hold_ok) chk("gap_hold", obs_taps, hold_taps);
  endtask

  task automatic run_frame(input int gap_pct, input int stop_at, input bit use_sof);
    strobes = 0;
    for (int idx = 0; idx < W * H; idx++) begin
      if (idx == stop_at) return;
      if ($urandom_range(0, 99) < gap_pct) idle();
      drive_pix(use_sof && idx == 0);
    end
    chk("strobe_count", TW'(strobes), TW'((W - 2) * (H - 2)));
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk); #1;
      chk("rst_out_valid", TW'(out_valid), TW'(0));
      chk("rst_frame_done", TW'(frame_done), TW'(0));
      chk("rst_taps", obs_taps, '0);
`ifdef WIN_COORD_EN
      chk("rst_coord", TW'({out_x, out_y}), TW'(0));
`endif
    end
    rst_n = 1'b1;
    mx = 0; my = 0;
    hold_ok = 1'b0;
    sb_q.delete(); coord_q.delete();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0;
    in_r = '0; in_g = '0; in_b = '0;
    mx = 0; my = 0; strobes = 0; acc_since = 0; first_at = -1; hold_ok = 1'b0;
    hold_taps = '0;

    // Reset state
    do_reset(3);

    // Continuous frame with sof
    run_frame(0, -1, 1);
    // Same frame with random gaps
    run_frame(30, -1, 1);
    // Abort at (4,3) with a fresh sof, then a full frame
    run_frame(0, 3 * W + 4, 1);
    run_frame(0, -1, 1);
    // Reset mid-frame; next frame starts without sof
    run_frame(0, 2 * W + 5, 1);
    do_reset(2);
    acc_since = 0; first_at = -1;
    run_frame(20, -1, 0);
    chk("first_strobe_after_reset", TW'(first_at), TW'(19));
    // One more gapped frame, sof driven
    run_frame(30, -1, 1);
    idle();
    chk("sb_empty", TW'(sb_q.size()), TW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
